game_round_fsm: RTL and testbench

Parametrised round controller for the quiz game: sequences IDLE → question → answer check → countdown → next question, for `NUM_PLAYERS` contestants.
- Adds over the two-player controller: per-player submit arbitration, wrong-answer lockout, an answer timeout, a configurable countdown and a round counter.
- Sits between the input debounce/edge detectors and the question generator, scoreboard and display mux; all timing is paced by the shared `game_tick` strobe.

---
 rtl/game_round_fsm.sv | 157 +++++++++++++++
 tb/tb_game_round_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_fsm.sv
// Quiz-game round controller: IDLE -> WAIT -> CHECK -> COUNT -> WAIT, with per-player
// submit arbitration, wrong-answer lockout, answer timeout and a round counter.
module game_round_fsm #(
  parameter int NUM_PLAYERS    = 2,
  parameter int CD_STEPS       = 3,
  parameter int TICKS_PER_STEP = 30,
  parameter int TIMEOUT_TICKS  = 600
) (
  input  logic                               clk_100mhz,
  input  logic                               reset,
  input  logic                               game_tick,
  input  logic                               start_game_event,
  input  logic [NUM_PLAYERS-1:0]             submit_event,
  input  logic                               is_ans_correct,
  input  logic                               is_game_over,
  output logic                               o_state_idle,
  output logic                               o_state_wait,
  output logic                               o_state_check,
  output logic                               o_state_countdown,
  output logic                               o_state_win,
  output logic                               o_new_question,
  output logic                               o_timeout,
  output logic [$clog2(NUM_PLAYERS)-1:0]     o_answer_player,
  output logic [NUM_PLAYERS-1:0]             o_locked,
  output logic [$clog2(CD_STEPS+1)-1:0]      countdown_val,
  output logic [7:0]                         o_round_count
);

  localparam int AP_W  = $clog2(NUM_PLAYERS);
  localparam int CV_W  = $clog2(CD_STEPS + 1);
  localparam int SUB_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int TO_W  = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_COUNT, S_WIN} state_t;

  state_t                 r_state;
  logic                   r_new_q;
  logic                   r_timeout;
  logic [AP_W-1:0]        r_answer;
  logic [NUM_PLAYERS-1:0] r_locked;
  logic [7:0]             r_round;
  logic [TO_W-1:0]        r_to_cnt;
  logic [CV_W-1:0]        r_step;
  logic [SUB_W-1:0]       r_sub;

  logic [NUM_PLAYERS-1:0] w_accept;
  logic [NUM_PLAYERS-1:0] w_lock_bit;
  logic [NUM_PLAYERS-1:0] w_lock_next;

  function automatic logic [AP_W-1:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = AP_W'(i);
  endfunction

  assign w_accept    = submit_event & ~r_locked;
  assign w_lock_bit  = NUM_PLAYERS'(1) << r_answer;
  assign w_lock_next = r_locked | w_lock_bit;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_new_q   <= 1'b0;
      r_timeout <= 1'b0;
      r_answer  <= '0;
      r_locked  <= '0;
      r_round   <= '0;
      r_to_cnt  <= '0;
      r_step    <= CV_W'(CD_STEPS);
      r_sub     <= '0;
    end else begin
      r_new_q   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_locked <= '0;
          r_to_cnt <= '0;
          r_round  <= '0;
          if (start_game_event) begin
            r_state <= S_WAIT;
            r_new_q <= 1'b1;
            r_round <= 8'd1;
          end
        end
        S_WAIT: begin
          // A submit in the same cycle as the final tick still wins over the timeout.
          if (|w_accept) begin
            r_answer <= lowest_idx(w_accept);
            r_state  <= S_CHECK;
          end else if (game_tick && TIMEOUT_TICKS != 0) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= S_COUNT;
              r_step    <= CV_W'(CD_STEPS);
              r_sub     <= '0;
            end
          end
        end
        S_CHECK: begin
          if (is_game_over) begin
            r_state <= S_WIN;
          end else if (is_ans_correct || w_lock_next == '1) begin
            if (!is_ans_correct) r_locked <= w_lock_next;
            r_state <= S_COUNT;
            r_step  <= CV_W'(CD_STEPS);
            r_sub   <= '0;
          end else begin
            // Wrong answer: same question continues, timeout keeps running.
            r_locked <= w_lock_next;
            r_state  <= S_WAIT;
          end
        end
        S_COUNT: begin
          if (game_tick) begin
            if (r_sub == SUB_W'(TICKS_PER_STEP - 1)) begin
              r_sub <= '0;
              if (r_step > CV_W'(1)) begin
                r_step <= r_step - CV_W'(1);
              end else begin
                r_state  <= S_WAIT;
                r_new_q  <= 1'b1;
                r_locked <= '0;
                r_to_cnt <= '0;
                if (r_round != 8'hFF) r_round <= r_round + 8'd1;
              end
            end else begin
              r_sub <= r_sub + SUB_W'(1);
            end
          end
        end
        S_WIN: begin
          if (start_game_event) begin
            r_state  <= S_IDLE;
            r_round  <= '0;
            r_locked <= '0;
            r_to_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_state_idle      = (r_state == S_IDLE);
  assign o_state_wait      = (r_state == S_WAIT);
  assign o_state_check     = (r_state == S_CHECK);
  assign o_state_countdown = (r_state == S_COUNT);
  assign o_state_win       = (r_state == S_WIN);
  assign o_new_question    = r_new_q;
  assign o_timeout         = r_timeout;
  assign o_answer_player   = r_answer;
  assign o_locked          = r_locked;
  assign o_round_count     = r_round;
  assign countdown_val     = (r_state == S_COUNT) ? r_step : CV_W'(CD_STEPS);

endmodule

// File: tb/tb_game_round_fsm.sv
// Bench for game_round_fsm: two instances (2 players / 4 players, no timeout) driven by
// shared stimulus; a tick-budget reference model feeds a scoreboard queue checked per cycle.
module tb_game_round_fsm;

  localparam int A_NP = 2, A_CD = 3, A_TPS = 30, A_TO = 10;
  localparam int B_NP = 4, B_CD = 5, B_TPS = 30, B_TO = 0;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_CHECK = 2, PH_COUNT = 3, PH_WIN = 4;

  logic       clk_100mhz = 1'b0;
  logic       reset = 1'b1;
  logic       game_tick = 1'b0;
  logic       start_game_event = 1'b0;
  logic       is_ans_correct = 1'b0;
  logic       is_game_over = 1'b0;
  logic [3:0] sub_all = '0;

  logic       a_idle, a_wait, a_check, a_count, a_win, a_nq, a_to;
  logic [0:0] a_ap;
  logic [1:0] a_lk;
  logic [1:0] a_cv;
  logic [7:0] a_rc;
  logic       b_idle, b_wait, b_check, b_count, b_win, b_nq, b_to;
  logic [1:0] b_ap;
  logic [3:0] b_lk;
  logic [2:0] b_cv;
  logic [7:0] b_rc;

  game_round_fsm #(.NUM_PLAYERS(A_NP), .CD_STEPS(A_CD), .TICKS_PER_STEP(A_TPS), .TIMEOUT_TICKS(A_TO)) u_a (
    .clk_100mhz(clk_100mhz), .reset(reset), .game_tick(game_tick),
    .start_game_event(start_game_event), .submit_event(sub_all[1:0]),
    .is_ans_correct(is_ans_correct), .is_game_over(is_game_over),
    .o_state_idle(a_idle), .o_state_wait(a_wait), .o_state_check(a_check),
    .o_state_countdown(a_count), .o_state_win(a_win), .o_new_question(a_nq),
    .o_timeout(a_to), .o_answer_player(a_ap), .o_locked(a_lk),
    .countdown_val(a_cv), .o_round_count(a_rc));

  game_round_fsm #(.NUM_PLAYERS(B_NP), .CD_STEPS(B_CD), .TICKS_PER_STEP(B_TPS), .TIMEOUT_TICKS(B_TO)) u_b (
    .clk_100mhz(clk_100mhz), .reset(reset), .game_tick(game_tick),
    .start_game_event(start_game_event), .submit_event(sub_all),
    .is_ans_correct(is_ans_correct), .is_game_over(is_game_over),
    .o_state_idle(b_idle), .o_state_wait(b_wait), .o_state_check(b_check),
    .o_state_countdown(b_count), .o_state_win(b_win), .o_new_question(b_nq),
    .o_timeout(b_to), .o_answer_player(b_ap), .o_locked(b_lk),
    .countdown_val(b_cv), .o_round_count(b_rc));

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    int ph; int waited; int left; int locked; int who; int rounds; bit nq; bit tmo;
  } mdl_t;

  typedef struct {
    int dut; int cyc; int ph; bit nq; bit tmo; int who; int locked; int cv; int rounds;
  } exp_t;

  mdl_t m[2];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   g_corr = 1'b0;
  bit   g_over = 1'b0;

  function automatic int np(int d);  return (d == 0) ? A_NP : B_NP;   endfunction
  function automatic int cdv(int d); return (d == 0) ? A_CD : B_CD;   endfunction
  function automatic int tps(int d); return (d == 0) ? A_TPS : B_TPS; endfunction
  function automatic int tov(int d); return (d == 0) ? A_TO : B_TO;   endfunction

  function automatic mdl_t new_question(mdl_t c);
    mdl_t n = c;
    n.ph = PH_WAIT; n.nq = 1'b1; n.locked = 0; n.waited = 0;
    n.rounds = (c.rounds < 255) ? c.rounds + 1 : 255;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t c, int d, bit rst, bit tick, bit st, int sub, bit corr, bit over);
    mdl_t n;
    int   all, acc;
    n = c; n.nq = 1'b0; n.tmo = 1'b0;
    all = (1 << np(d)) - 1;
    if (rst) begin
      n.ph = PH_IDLE; n.waited = 0; n.left = 0; n.locked = 0; n.who = 0; n.rounds = 0;
      return n;
    end
    case (c.ph)
      PH_IDLE: if (st) n = new_question(c);
      PH_WAIT: begin
        acc = sub & all & ~c.locked;
        if (acc != 0) begin
          n.ph = PH_CHECK;
          for (int i = np(d) - 1; i >= 0; i--) if (acc[i]) n.who = i;
        end else if (tick) begin
          n.waited = c.waited + 1;
          if (tov(d) != 0 && n.waited == tov(d)) begin
            n.tmo = 1'b1; n.ph = PH_COUNT; n.left = cdv(d) * tps(d);
          end
        end
      end
      PH_CHECK: begin
        if (over) n.ph = PH_WIN;
        else if (corr) begin n.ph = PH_COUNT; n.left = cdv(d) * tps(d); end
        else begin
          n.locked = c.locked | (1 << c.who);
          if (n.locked == all) begin n.ph = PH_COUNT; n.left = cdv(d) * tps(d); end
          else n.ph = PH_WAIT;
        end
      end
      PH_COUNT: if (tick) begin
        n.left = c.left - 1;
        if (n.left == 0) n = new_question(n);
      end
      default: if (st) begin
        n.ph = PH_IDLE; n.rounds = 0; n.locked = 0; n.waited = 0;
      end
    endcase
    return n;
  endfunction

  function automatic exp_t mk_exp(mdl_t c, int d, int k);
    exp_t e;
    e.dut = d; e.cyc = k; e.ph = c.ph; e.nq = c.nq; e.tmo = c.tmo;
    e.who = c.who; e.locked = c.locked; e.rounds = c.rounds;
    // Displayed step is the number of whole-or-partial steps still to run.
    e.cv = (c.ph == PH_COUNT) ? (c.left + tps(d) - 1) / tps(d) : cdv(d);
    return e;
  endfunction

  task automatic go(input bit rst, input bit st, input logic [3:0] sb);
    bit tk;
    tk = (cyc % 4 == 3);
    reset = rst; start_game_event = st; sub_all = sb; game_tick = tk;
    is_ans_correct = g_corr; is_game_over = g_over;
    for (int d = 0; d < 2; d++) begin
      m[d] = mstep(m[d], d, rst, tk, st, int'(sb), g_corr, g_over);
      sbq.push_back(mk_exp(m[d], d, cyc));
    end
    cyc++;
    @(posedge clk_100mhz);
    #2;
  endtask

  task automatic wait_ph(input int d, input int ph, input int budget);
    int k;
    k = 0;
    while (m[d].ph != ph && k < budget) begin
      go(1'b0, 1'b0, 4'b0000);
      k++;
    end
    n_vec++;
    if (m[d].ph != ph) begin
      n_bad++;
      $display("FAIL wait_ph dut%0d: phase %0d after %0d cycles, required %0d", d, m[d].ph, k, ph);
    end
  endtask

  // Monitor: pops the expectations pushed before this edge and compares them.
  initial begin
    exp_t        e;
    logic [4:0]  af, ef;
    bit          anq, ato;
    int          aap, alk, acv, arc;
    forever begin
      @(posedge clk_100mhz);
      #1;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.dut == 0) begin
          af = {a_idle, a_wait, a_check, a_count, a_win}; anq = a_nq; ato = a_to;
          aap = int'(a_ap); alk = int'(a_lk); acv = int'(a_cv); arc = int'(a_rc);
        end else begin
          af = {b_idle, b_wait, b_check, b_count, b_win}; anq = b_nq; ato = b_to;
          aap = int'(b_ap); alk = int'(b_lk); acv = int'(b_cv); arc = int'(b_rc);
        end
        ef = 5'b10000 >> e.ph;
        n_vec++;
        if (af !== ef || anq !== e.nq || ato !== e.tmo || aap != e.who ||
            alk != e.locked || acv != e.cv || arc != e.rounds) begin
          n_bad++;
          $display("FAIL dut%0d cyc %0d: got st=%b nq=%b to=%b ap=%0d lk=%0h cv=%0d rc=%0d, required st=%b nq=%b to=%b ap=%0d lk=%0h cv=%0d rc=%0d",
                   e.dut, e.cyc, af, anq, ato, aap, alk, acv, arc,
                   ef, e.nq, e.tmo, e.who, e.locked, e.cv, e.rounds);
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) go(1'b1, 1'b0, 4'b0000);

    // Start, correct answer from P0, full countdown back to a new question.
    g_corr = 1'b1; g_over = 1'b0;
    go(1'b0, 1'b1, 4'b0000);
    go(1'b0, 1'b0, 4'b0000);
    go(1'b0, 1'b0, 4'b0001);
    wait_ph(0, PH_WAIT, 500);

    // Simultaneous submits, lockout, ignored locked submit, full lockout.
    g_corr = 1'b0;
    go(1'b0, 1'b0, 4'b0011);
    go(1'b0, 1'b0, 4'b0000);
    go(1'b0, 1'b0, 4'b0001);
    go(1'b0, 1'b0, 4'b0000);
    go(1'b0, 1'b0, 4'b0010);
    go(1'b0, 1'b0, 4'b0000);
    wait_ph(0, PH_WAIT, 500);

    // Timeout, then a submit landing on the tenth-tick cycle.
    wait_ph(0, PH_COUNT, 100);
    wait_ph(0, PH_WAIT, 500);
    guard = 0;
    while (!(m[0].ph == PH_WAIT && m[0].waited == A_TO - 1 && cyc % 4 == 3) && guard < 100) begin
      go(1'b0, 1'b0, 4'b0000);
      guard++;
    end
    g_over = 1'b1;
    go(1'b0, 1'b0, 4'b0001);
    go(1'b0, 1'b0, 4'b0000);
    repeat (3) go(1'b0, 1'b0, 4'b0011);
    go(1'b0, 1'b1, 4'b0000);
    g_over = 1'b0;
    go(1'b0, 1'b0, 4'b0000);

    // Reset in the middle of a countdown.
    go(1'b0, 1'b1, 4'b0000);
    g_corr = 1'b1;
    go(1'b0, 1'b0, 4'b0001);
    repeat (100) go(1'b0, 1'b0, 4'b0000);
    go(1'b1, 1'b0, 4'b0000);
    go(1'b0, 1'b0, 4'b0000);

    // Four-player instance: long wait without timeout, lock all players, 5-step countdown.
    go(1'b0, 1'b1, 4'b0000);
    repeat (60) go(1'b0, 1'b0, 4'b0000);
    g_corr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      go(1'b0, 1'b0, 4'(1 << p));
      go(1'b0, 1'b0, 4'b0000);
    end
    wait_ph(1, PH_WAIT, 700);

    // Randomised traffic.
    for (int k = 0; k < 6000; k++) begin
      bit         st, rs;
      logic [3:0] sb;
      g_corr = 1'($urandom_range(0, 1));
      g_over = ($urandom_range(0, 9) == 0);
      st     = ($urandom_range(0, 15) == 0);
      rs     = ($urandom_range(0, 499) == 0);
      sb     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      go(rs, st, sb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
